// File: rtl/sram_confreg.sv
// sram_confreg: board config register window (LED/NUM/SWITCH/BTN/TIMER); CONFREG_TIMER_IRQ_EN adds timer compare IRQ
module sram_confreg #(
  parameter logic [15:0] BASE_HI   = 16'h1faf,
  parameter logic [31:0] SIMU_FLAG = 32'hffff_ffff
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic [15:0] led,
  output logic [1:0]  led_rg0,
  output logic [1:0]  led_rg1,
  output logic [31:0] num_data,
  input  logic [7:0]  switch,
  input  logic [15:0] btn_key,
  output logic        timer_irq
);
  logic        hit, wr;
  logic [15:0] off, led_r;
  logic [31:0] sel_val, w_val, timer, timer_nxt;
  logic [7:0]  sw_s1, sw_s2;
`ifdef CONFREG_TIMER_IRQ_EN
  logic [31:0] cmp_r;
  logic        pending, irq_r, set, clr;
`endif
  assign hit = sram_en && sram_addr[31:16] == BASE_HI;
  assign off = sram_addr[15:0];
  assign wr  = hit && |sram_wen;
  always_comb begin
    sel_val = 32'h0;
    case (off)
      16'hf000: sel_val = {16'h0, led_r};
      16'hf004: sel_val = {30'h0, led_rg0};
      16'hf008: sel_val = {30'h0, led_rg1};
      16'hf010: sel_val = num_data;
      16'hf020: sel_val = {24'h0, sw_s2};
      16'hf024: sel_val = {16'h0, btn_key};
      16'he000: sel_val = timer;
`ifdef CONFREG_TIMER_IRQ_EN
      16'he004: sel_val = cmp_r;
      16'he008: sel_val = {31'h0, pending};
`endif
      16'hff0c: sel_val = SIMU_FLAG;
      default:  sel_val = 32'h0;
    endcase
  end
  // byte-merge of the addressed register's current value with the write data
  always_comb
    for (int i = 0; i < 4; i++)
      w_val[8*i +: 8] = sram_wen[i] ? sram_wdata[8*i +: 8] : sel_val[8*i +: 8];
  assign timer_nxt = (wr && off == 16'he000) ? w_val : timer + 32'h1;
`ifdef CONFREG_TIMER_IRQ_EN
  assign set = cmp_r != 32'h0 && timer_nxt == cmp_r;
  assign clr = wr && off == 16'he008 && sram_wen[0] && sram_wdata[0];
  assign timer_irq = irq_r;
`else
  assign timer_irq = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sram_rdata <= 32'h0;
      led_r      <= 16'h0;
      led_rg0    <= 2'h0;
      led_rg1    <= 2'h0;
      num_data   <= 32'h0;
      timer      <= 32'h0;
      sw_s1      <= 8'h0;
      sw_s2      <= 8'h0;
`ifdef CONFREG_TIMER_IRQ_EN
      cmp_r      <= 32'h0;
      pending    <= 1'b0;
      irq_r      <= 1'b0;
`endif
    end else begin
      sw_s1 <= switch;
      sw_s2 <= sw_s1;
      timer <= timer_nxt;
      if (sram_en && sram_wen == 4'h0) sram_rdata <= hit ? sel_val : 32'h0;
      if (wr && off == 16'hf000) led_r <= w_val[15:0];
      if (wr && off == 16'hf004) led_rg0 <= w_val[1:0];
      if (wr && off == 16'hf008) led_rg1 <= w_val[1:0];
      if (wr && off == 16'hf010) num_data <= w_val;
`ifdef CONFREG_TIMER_IRQ_EN
      if (wr && off == 16'he004) cmp_r <= w_val;
      pending <= set || (pending && !clr);
      irq_r   <= pending;
`endif
    end
  end
  assign led = ~led_r;
endmodule

// File: tb/tb_sram_confreg.sv
// tb_sram_confreg: directed checks of the config register window
module tb_sram_confreg;
  logic        clk = 0, resetn = 0, sram_en = 0;
  logic [3:0]  sram_wen = 0;
  logic [31:0] sram_addr = 0, sram_wdata = 0, sram_rdata, num_data;
  logic [15:0] led, btn_key = 0;
  logic [1:0]  led_rg0, led_rg1;
  logic [7:0]  switch = 0;
  logic        timer_irq;
  int          errors = 0, checks = 0;

  sram_confreg dut (.clk(clk), .resetn(resetn), .sram_en(sram_en), .sram_wen(sram_wen),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .led(led),
    .led_rg0(led_rg0), .led_rg1(led_rg1), .num_data(num_data), .switch(switch),
    .btn_key(btn_key), .timer_irq(timer_irq));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic en, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    sram_en = en; sram_wen = wen; sram_addr = addr; sram_wdata = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata);
    cyc(1, wen, addr, wdata);
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    cyc(1, 4'h0, addr, 32'h0);
    chk(tag, sram_rdata, exp);
  endtask

  initial begin
    resetn = 0;
    idle(); idle();
    resetn = 1;
    chk("rst_rdata", sram_rdata, 32'h0);
    chk("rst_led", {16'h0, led}, 32'hffff);
    chk("rst_irq", {31'h0, timer_irq}, 32'h0);
    chk("rst_num", num_data, 32'h0);
    chk("rst_rg", {28'h0, led_rg1, led_rg0}, 32'h0);
    rd("rd_led_rst", 32'h1faf_f000, 32'h0);
    wr(32'h1faf_f010, 4'b0011, 32'h1234_5678);
    chk("num_lo", num_data, 32'h0000_5678);
    rd("rd_num_lo", 32'h1faf_f010, 32'h0000_5678);
    wr(32'h1faf_f010, 4'b1100, 32'habcd_0000);
    chk("num_hi", num_data, 32'habcd_5678);
    rd("rd_num_hi", 32'h1faf_f010, 32'habcd_5678);
    idle();
    chk("hold_idle", sram_rdata, 32'habcd_5678);
    wr(32'h1faf_f000, 4'hf, 32'hffff_1234);
    chk("hold_wr", sram_rdata, 32'habcd_5678);
    chk("led_out", {16'h0, led}, 32'h0000_edcb);
    rd("rd_led", 32'h1faf_f000, 32'h0000_1234);
    wr(32'h1faf_f004, 4'hf, 32'hffff_ffff);
    wr(32'h1faf_f008, 4'h1, 32'h0000_0002);
    chk("rg_out", {28'h0, led_rg1, led_rg0}, 32'h0000_000b);
    rd("rd_rg0", 32'h1faf_f004, 32'h3);
    switch = 8'h5a;
    idle();
    rd("sw_early", 32'h1faf_f020, 32'h0);
    rd("sw_sync", 32'h1faf_f020, 32'h5a);
    rd("sw_nohit", 32'h1fae_f020, 32'h0);
    wr(32'h1faf_f020, 4'hf, 32'hffff_ffff);
    rd("sw_ro", 32'h1faf_f020, 32'h5a);
    btn_key = 16'ha55a;
    rd("btn", 32'h1faf_f024, 32'h0000_a55a);
    rd("simu", 32'h1faf_ff0c, 32'hffff_ffff);
    rd("unmapped", 32'h1faf_f0f0, 32'h0);
    wr(32'h1faf_e000, 4'hf, 32'hffff_fffe);
    idle();
    rd("tmr_ff", 32'h1faf_e000, 32'hffff_ffff);
    rd("tmr_wrap", 32'h1faf_e000, 32'h0);
`ifdef CONFREG_TIMER_IRQ_EN
    wr(32'h1faf_e004, 4'hf, 32'd10);
    rd("rd_cmp", 32'h1faf_e004, 32'd10);
    wr(32'h1faf_e000, 4'hf, 32'd5);
    for (int i = 1; i <= 5; i++) begin
      idle();
      chk($sformatf("irq_low%0d", i), {31'h0, timer_irq}, 32'h0);
    end
    idle();
    chk("irq_rise", {31'h0, timer_irq}, 32'h1);
    wr(32'h1faf_e008, 4'h1, 32'h1);
    idle();
    chk("irq_w1c", {31'h0, timer_irq}, 32'h0);
    rd("stat_clr", 32'h1faf_e008, 32'h0);
    wr(32'h1faf_e000, 4'hf, 32'd5);
    idle(); idle(); idle(); idle();
    wr(32'h1faf_e008, 4'h1, 32'h1);
    rd("stat_setwins", 32'h1faf_e008, 32'h1);
    chk("irq_setwins", {31'h0, timer_irq}, 32'h1);
    wr(32'h1faf_e008, 4'h1, 32'h1);
    idle();
    chk("irq_clr2", {31'h0, timer_irq}, 32'h0);
`else
    wr(32'h1faf_e004, 4'hf, 32'd10);
    rd("cmp_absent", 32'h1faf_e004, 32'h0);
    wr(32'h1faf_e000, 4'hf, 32'd5);
    for (int i = 0; i < 8; i++) idle();
    chk("irq_tied", {31'h0, timer_irq}, 32'h0);
    rd("stat_absent", 32'h1faf_e008, 32'h0);
`endif
    rd("pre_rst", 32'h1faf_f010, 32'habcd_5678);
    resetn = 0;
    wr(32'h1faf_f000, 4'hf, 32'h0000_00ff);
    resetn = 1;
    chk("rstwr_led", {16'h0, led}, 32'hffff);
    chk("rstwr_rdata", sram_rdata, 32'h0);
    rd("rstwr_reg", 32'h1faf_f000, 32'h0);
    rd("rstwr_num", 32'h1faf_f010, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
